// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request feeding a 2-entry in-order {inst, pc} FIFO.
// Optional macro INST_FETCH_ALIGN_CHECK_EN adds misalign_err and halts fetch after an unaligned redirect.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
`ifdef INST_FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    entry_t      fifo_q [2];

    logic halt;
    logic can_req;
    logic issue;
    logic push;
    logic pop;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic err_q, err_d;

    assign halt         = err_q;
    assign misalign_err = err_q;

    always_comb err_d = redirect ? (redirect_pc[1:0] != 2'b00) : err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign halt = 1'b0;
`endif

    // Request eligibility never looks at imem_ready, so the handshake stays loop-free.
    assign can_req = (state_q == ST_REQ) && (count_q != 2'd2) && !halt;
    assign issue   = can_req && imem_ready;
    assign push    = (state_q == ST_WAIT) && imem_rvalid && !redirect;
    assign pop     = inst_valid && inst_ready && !redirect;

    assign imem_req   = can_req && !reset;
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = inst_valid ? fifo_q[rd_ptr_q].inst : 32'h0;
    assign inst_pc    = inst_valid ? fifo_q[rd_ptr_q].pc   : 64'h0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            ST_REQ:  if (issue) state_d = redirect ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid)   state_d = ST_REQ;
                else if (redirect) state_d = ST_DROP;
            end
            ST_DROP: if (imem_rvalid) state_d = ST_REQ;
            default: state_d = ST_REQ;
        endcase

        if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc & ~64'h3;
            count_d    = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC & ~64'h3;
            req_pc_q   <= 64'h0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; outputs are masked until count_q marks an entry valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {imem_rdata, req_pc_q};
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request valid.
REQ-005 imem_addr  output  64  fetch byte address; bits [1:0] always 0.
REQ-006 imem_ready  input  1  memory accepts request this cycle (imem_req && imem_ready = issue).
REQ-007 imem_rvalid  input  1  fetch response valid; responses in order, at least 1 cycle after issue.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-010 redirect_pc  input  64  redirect target.
REQ-011 inst  output  32  instruction word to the immediate generator and decoder.
REQ-012 inst_pc  output  64  PC of inst.
REQ-013 inst_valid  output  1  inst/inst_pc valid.
REQ-014 inst_ready  input  1  consumer accepts (inst_valid && inst_ready = pop).

Function
REQ-015 2-entry in-order FIFO holds {inst, pc}; inst/inst_pc driven from head; inst_valid = count != 0.
REQ-016 At most one outstanding request; imem_req = 1 only in state REQ and only when count + outstanding < 2.
REQ-017 States: REQ (request asserted or waiting for space), WAIT (one request outstanding), DROP (outstanding response discarded).
REQ-018 REQ -> WAIT on issue; fetch_pc += 4 on issue; imem_addr = fetch_pc.
REQ-019 WAIT -> REQ on imem_rvalid; the word is pushed with pc = issued address; same-cycle pop and push allowed at count 2 only if pop occurs (space is guaranteed by REQ-016).
REQ-020 Redirect (highest priority): FIFO cleared, fetch_pc <= redirect_pc, no push that cycle; WAIT -> DROP, REQ/DROP -> REQ (DROP stays DROP if response not yet seen).
REQ-021 DROP: next imem_rvalid discarded, -> REQ; no request issued while in DROP.
REQ-022 Redirect in same cycle as issue: the issued request counts as outstanding, state -> DROP.
REQ-023 Pop with count 0 ignored; FIFO pointers wrap modulo 2.
REQ-024 imem_rvalid in state REQ (no outstanding) ignored.
REQ-025 Outputs combinationally independent of inst_ready; imem_req not dependent on imem_ready.

Reset
REQ-026 On reset assertion, asynchronously: state = REQ, fetch_pc = RESET_PC, count = 0, outstanding = 0, inst_valid = 0, inst = 0, inst_pc = 0, imem_req = 0 while reset high.
REQ-027 Reset mid-fetch abandons the outstanding request; a late response after release is ignored by REQ-024.
REQ-028 First request issued in the first cycle after reset deasserts.

Configuration
REQ-029 Macro INST_FETCH_ALIGN_CHECK_EN adds output misalign_err (1 bit, reset 0).
REQ-030 With macro: redirect with redirect_pc[1:0] != 0 sets misalign_err, clears FIFO, and halts requests until a redirect with aligned target clears it.
REQ-031 Without macro: no misalign_err port; redirect_pc[1:0] forced to 0 silently.

Verification
REQ-032 RESET_PC=64'h1000, reset release, memory 1-cycle latency, inst_ready=1 -> imem_addr 1000,1004,1008; inst_pc matches, one inst per 2 cycles.
REQ-033 inst_ready=0 -> exactly 2 words buffered, imem_req stays 0; raise inst_ready -> both popped in order, fetching resumes at 1008.
REQ-034 Redirect to 64'h2000 while request to 1004 outstanding -> response for 1004 dropped; next issued addr 2000; first inst_pc 2000.
REQ-035 Redirect coinciding with pop at count 2 and rvalid -> FIFO empty next cycle, inst_valid 0.
REQ-036 Reset asserted mid-WAIT -> all outputs 0 immediately; late rvalid with 32'hDEADBEEF never appears on inst.
REQ-037 With INST_FETCH_ALIGN_CHECK_EN, redirect to 64'h2002 -> misalign_err 1, imem_req 0; redirect to 64'h3000 -> misalign_err 0, fetch at 3000; without macro, 64'h2002 fetches 2000.
